axi_slave_push_fsm_rd_mc: RTL and testbench

AXI_SLAVE_PUSH_FSM_RD_MC -- requirements
Module: axi_slave_push_fsm_rd_mc

---
 rtl/axi_slave_push_fsm_rd_mc.sv | 148 ++++++++++++++
 tb/tb_axi_slave_push_fsm_rd_mc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_push_fsm_rd_mc.sv
// axi_slave_push_fsm_rd_mc: round-robin AR channel arbiter pushing requests into a FIFO with tagging,
// outstanding limit and illegal-type handling; define AXI_SLAVE_RD_ERR_RESP_EN for the ERR response state.
module axi_slave_push_fsm_rd_mc #(
    parameter int NUM_CH    = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 64,
    parameter int USER_W    = 3,
    parameter int TAG_W     = 8,
    parameter int MAX_OUTST = 16,
    localparam int FW       = TAG_W + ID_W + ADDR_W + 13 + USER_W
) (
    input  logic                     axi_clk,
    input  logic                     ARESET,
    input  logic [NUM_CH-1:0]        ar_valid,
    output logic [NUM_CH-1:0]        ar_ready,
    input  logic [NUM_CH*ID_W-1:0]   ar_id,
    input  logic [NUM_CH*ADDR_W-1:0] ar_addr,
    input  logic [NUM_CH*8-1:0]      ar_len,
    input  logic [NUM_CH*3-1:0]      ar_size,
    input  logic [NUM_CH*2-1:0]      ar_burst,
    input  logic [NUM_CH*USER_W-1:0] ar_user,
    output logic                     fifo_wr_en,
    output logic [FW-1:0]            fifo_wr_data,
    input  logic                     fifo_full,
    output logic [TAG_W-1:0]         rec_tag,
    input  logic                     rec_busy,
    input  logic                     cpl_release,
    output logic                     err_valid,
    input  logic                     err_ready,
    output logic [ID_W-1:0]          err_id,
    output logic [1:0]               err_resp
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

`ifdef AXI_SLAVE_RD_ERR_RESP_EN
    typedef enum logic [1:0] {IDLE, PUSH, ERR} state_t;
`else
    typedef enum logic [0:0] {IDLE, PUSH} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    grant, rr_ptr, win, idx, ack_ch;
    logic [TAG_W-2:0] tag_ptr;
    logic [OW-1:0]    outst_cnt;
    logic [2:0]       win_type;
    logic             any_valid, legal, open, push, rel, ack;

    function automatic logic [CW-1:0] nxt(input logic [CW-1:0] x);
        return (int'(x) + 1 == NUM_CH) ? '0 : x + CW'(1);
    endfunction

    // scan downwards so the lowest offset from rr_ptr is the one left standing
    always_comb begin
        win = rr_ptr;
        idx = rr_ptr;
        any_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % NUM_CH);
            if (ar_valid[idx]) begin
                win = idx;
                any_valid = 1'b1;
            end
        end
    end

    assign win_type = ar_user[win*USER_W +: 3];
    assign legal    = win_type inside {3'b001, 3'b101, 3'b010, 3'b011};
    assign open     = outst_cnt < OW'(MAX_OUTST);
    assign push     = !ARESET && state == PUSH && !fifo_full && ar_valid[grant];
    assign rel      = cpl_release && (push || outst_cnt != '0);
    assign rec_tag  = ARESET ? {1'b1, {(TAG_W-1){1'b0}}} : {1'b1, tag_ptr};

`ifdef AXI_SLAVE_RD_ERR_RESP_EN
    logic err_hs;
    assign err_hs    = !ARESET && state == ERR && err_ready;
    assign ack       = push || err_hs;
    assign ack_ch    = grant;
    assign err_valid = !ARESET && state == ERR;
    assign err_id    = err_valid ? ar_id[grant*ID_W +: ID_W] : '0;
    assign err_resp  = err_valid ? 2'b10 : 2'b00;
`else
    logic drop, unused_err_ready;
    assign drop             = !ARESET && state == IDLE && any_valid && !legal;
    assign ack              = push || drop;
    assign ack_ch           = drop ? win : grant;
    assign err_valid        = 1'b0;
    assign err_id           = '0;
    assign err_resp         = 2'b00;
    assign unused_err_ready = err_ready;
`endif

    always_comb begin
        ar_ready = '0;
        ar_ready[ack_ch] = ack && ar_valid[ack_ch];
    end

    assign fifo_wr_en   = push;
    assign fifo_wr_data = push ? {rec_tag, ar_id[grant*ID_W +: ID_W], ar_addr[grant*ADDR_W +: ADDR_W],
                                  ar_len[grant*8 +: 8], ar_size[grant*3 +: 3], ar_burst[grant*2 +: 2],
                                  ar_user[grant*USER_W +: USER_W]} : '0;

    always_ff @(posedge axi_clk) begin
        if (ARESET) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            tag_ptr   <= '0;
            outst_cnt <= '0;
        end else begin
            if (push != rel)
                outst_cnt <= push ? outst_cnt + OW'(1) : outst_cnt - OW'(1);
            case (state)
                IDLE:
                    if (any_valid) begin
                        if (!legal) begin
                            grant <= win;
`ifdef AXI_SLAVE_RD_ERR_RESP_EN
                            state <= ERR;
`else
                            rr_ptr <= nxt(win);
`endif
                        end else if (rec_busy) begin
                            tag_ptr <= tag_ptr + 1'b1;
                        end else if (!fifo_full && open) begin
                            grant <= win;
                            state <= PUSH;
                        end
                    end
                PUSH: begin
                    state <= IDLE;
                    if (push) begin
                        tag_ptr <= tag_ptr + 1'b1;
                        rr_ptr  <= nxt(grant);
                    end
                end
`ifdef AXI_SLAVE_RD_ERR_RESP_EN
                ERR:
                    if (err_ready) begin
                        state  <= IDLE;
                        rr_ptr <= nxt(grant);
                    end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_push_fsm_rd_mc.sv
// tb_axi_slave_push_fsm_rd_mc: directed vector table plus hand sequences for the AR push FSM
// (MAX_OUTST=2 instance; the illegal-request sequence follows AXI_SLAVE_RD_ERR_RESP_EN).
module tb_axi_slave_push_fsm_rd_mc;
    logic        axi_clk = 1'b0;
    logic        ARESET;
    logic [1:0]  ar_valid, ar_ready;
    logic [3:0]  id0, id1;
    logic [63:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic [2:0]  size0, size1, u0, u1;
    logic [1:0]  burst0, burst1;
    logic        fifo_wr_en, fifo_full, rec_busy, cpl_release, err_valid, err_ready;
    logic [91:0] fifo_wr_data;
    logic [7:0]  rec_tag;
    logic [3:0]  err_id;
    logic [1:0]  err_resp;
    int checks = 0;
    int failures = 0;

    always #5 axi_clk = ~axi_clk;

    axi_slave_push_fsm_rd_mc #(.MAX_OUTST(2)) dut (
        .axi_clk(axi_clk), .ARESET(ARESET), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_id({id1, id0}), .ar_addr({addr1, addr0}), .ar_len({len1, len0}),
        .ar_size({size1, size0}), .ar_burst({burst1, burst0}), .ar_user({u1, u0}),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .rec_tag(rec_tag), .rec_busy(rec_busy), .cpl_release(cpl_release),
        .err_valid(err_valid), .err_ready(err_ready), .err_id(err_id), .err_resp(err_resp)
    );

    typedef struct {
        logic [1:0] vld;
        logic [2:0] t0, t1;
        logic       full, busy, rel;
        logic [1:0] rdy;
        logic       wr;
        logic [7:0] tag;
        logic       ch;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    function automatic logic [91:0] pack(input logic [7:0] t, input logic c);
        return c ? {t, id1, addr1, len1, size1, burst1, u1} : {t, id0, addr0, len0, size0, burst0, u0};
    endfunction

    task automatic do_reset;
        ARESET = 1'b1;
        ar_valid = 2'b00; fifo_full = 0; rec_busy = 0; cpl_release = 0; err_ready = 0;
        u0 = 3'b001; u1 = 3'b010; id0 = 4'd3; id1 = 4'd9;
        tick;
        tick;
        ARESET = 1'b0;
    endtask

    task automatic wait_wr(input string nm, input int lim);
        bit got = 0;
        for (int k = 0; k < lim && !got; k++) begin
            #1;
            if (fifo_wr_en) got = 1;
            else tick;
        end
        chk(nm, got, 1);
    endtask

    initial begin
        int n;
        addr0 = 64'h1000; addr1 = 64'h2000; len0 = 8'd0; len1 = 8'd3;
        size0 = 3'd2; size1 = 3'd3; burst0 = 2'd1; burst1 = 2'd1;
        tv[0]  = '{2'b01, 3'b001, 3'b010, 0, 0, 0, 2'b00, 0, 8'h80, 0};
        tv[1]  = '{2'b01, 3'b001, 3'b010, 0, 0, 0, 2'b01, 1, 8'h80, 0};
        tv[2]  = '{2'b00, 3'b001, 3'b010, 0, 0, 1, 2'b00, 0, 8'h81, 0};
        tv[3]  = '{2'b11, 3'b101, 3'b011, 0, 0, 0, 2'b00, 0, 8'h81, 0};
        tv[4]  = '{2'b11, 3'b101, 3'b011, 0, 0, 0, 2'b10, 1, 8'h81, 1};
        tv[5]  = '{2'b11, 3'b101, 3'b011, 0, 0, 1, 2'b00, 0, 8'h82, 0};
        tv[6]  = '{2'b11, 3'b101, 3'b011, 0, 0, 0, 2'b01, 1, 8'h82, 0};
        tv[7]  = '{2'b11, 3'b101, 3'b011, 0, 0, 1, 2'b00, 0, 8'h83, 0};
        tv[8]  = '{2'b11, 3'b101, 3'b011, 0, 0, 0, 2'b10, 1, 8'h83, 1};
        tv[9]  = '{2'b01, 3'b001, 3'b010, 0, 1, 1, 2'b00, 0, 8'h84, 0};
        tv[10] = '{2'b01, 3'b001, 3'b010, 0, 0, 0, 2'b00, 0, 8'h85, 0};
        tv[11] = '{2'b01, 3'b001, 3'b010, 1, 0, 0, 2'b00, 0, 8'h85, 0};
        tv[12] = '{2'b01, 3'b001, 3'b010, 1, 0, 0, 2'b00, 0, 8'h85, 0};
        tv[13] = '{2'b01, 3'b001, 3'b010, 0, 0, 0, 2'b00, 0, 8'h85, 0};
        tv[14] = '{2'b01, 3'b001, 3'b010, 0, 0, 0, 2'b01, 1, 8'h85, 0};
        tv[15] = '{2'b00, 3'b001, 3'b010, 0, 0, 1, 2'b00, 0, 8'h86, 0};

        // reset behaviour with traffic pending
        do_reset;
        ARESET = 1'b1;
        ar_valid = 2'b11;
        tick;
        #1;
        chk("rst_ready", ar_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_rec_tag", rec_tag, 8'h80);
        chk("rst_err", {err_valid, err_id, err_resp}, 0);
        chk("rst_outst", dut.outst_cnt, 0);

        do_reset;
        for (int i = 0; i < 16; i++) begin
            ar_valid = tv[i].vld; u0 = tv[i].t0; u1 = tv[i].t1;
            fifo_full = tv[i].full; rec_busy = tv[i].busy; cpl_release = tv[i].rel;
            #1;
            chk($sformatf("vec%0d_ready", i), ar_ready, tv[i].rdy);
            chk($sformatf("vec%0d_wr_en", i), fifo_wr_en, tv[i].wr);
            chk($sformatf("vec%0d_tag", i), rec_tag, tv[i].tag);
            if (tv[i].wr) chk($sformatf("vec%0d_data", i), fifo_wr_data, pack(tv[i].tag, tv[i].ch));
            tick;
        end
        cpl_release = 0; ar_valid = 0; rec_busy = 0; fifo_full = 0;

        // outstanding limit of two
        do_reset;
        ar_valid = 2'b01;
        wait_wr("bp_push1", 6);
        chk("bp_push1_data", fifo_wr_data, pack(8'h80, 0));
        tick;
        chk("bp_outst1", dut.outst_cnt, 1);
        wait_wr("bp_push2", 6);
        tick;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (fifo_wr_en) n++;
            tick;
        end
        chk("bp_stall", n, 0);
        cpl_release = 1;
        tick;
        cpl_release = 0;
        wait_wr("bp_push3", 6);
        chk("bp_push3_tag", fifo_wr_data[91:84], 8'h82);
        tick;
        chk("bp_outst_full", dut.outst_cnt, 2);
        ar_valid = 0;
        cpl_release = 1;
        tick;
        cpl_release = 0;
        chk("bp_outst_rel", dut.outst_cnt, 1);
        ar_valid = 2'b01;
        wait_wr("bp_push4", 6);
        cpl_release = 1;
        tick;
        cpl_release = 0;
        chk("bp_outst_coinc", dut.outst_cnt, 1);
        ar_valid = 0;

        // busy tag skipping and tag wrap
        do_reset;
        ar_valid = 2'b01;
        rec_busy = 1;
        #1;
        chk("busy_tag0", rec_tag, 8'h80);
        tick;
        chk("busy_tag1", rec_tag, 8'h81);
        chk("busy_no_wr", fifo_wr_en, 0);
        for (int k = 0; k < 126; k++) tick;
        chk("wrap_pre", rec_tag, 8'hFF);
        rec_busy = 0;
        wait_wr("wrap_push", 4);
        chk("wrap_data", fifo_wr_data, pack(8'hFF, 0));
        tick;
        chk("wrap_post", rec_tag, 8'h80);
        ar_valid = 0;

        // reset during PUSH
        do_reset;
        ar_valid = 2'b01;
        wait_wr("rp_push0", 6);
        tick;
        ar_valid = 2'b10;
        #1;
        chk("rp_idle_wr", fifo_wr_en, 0);
        tick;
        ARESET = 1;
        #1;
        chk("rp_rst_wr", fifo_wr_en, 0);
        chk("rp_rst_ready", ar_ready, 0);
        tick;
        ARESET = 0;
        ar_valid = 2'b11;
        #1;
        chk("rp_after_wr", fifo_wr_en, 0);
        chk("rp_after_tag", rec_tag, 8'h80);
        chk("rp_after_outst", dut.outst_cnt, 0);
        wait_wr("rp_push", 6);
        chk("rp_push_ready", ar_ready, 2'b01);
        chk("rp_push_data", fifo_wr_data, pack(8'h80, 0));
        tick;
        ar_valid = 0;

        // illegal request type
        do_reset;
        u0 = 3'b111;
        id0 = 4'd5;
        ar_valid = 2'b01;
`ifdef AXI_SLAVE_RD_ERR_RESP_EN
        #1;
        chk("err_idle", err_valid, 0);
        tick;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("err_hold%0d", k), {err_valid, err_id, err_resp}, {1'b1, 4'd5, 2'b10});
            chk($sformatf("err_hold%0d_ready", k), ar_ready, 0);
            chk($sformatf("err_hold%0d_wr", k), fifo_wr_en, 0);
            tick;
        end
        err_ready = 1;
        #1;
        chk("err_ack_ready", ar_ready, 2'b01);
        chk("err_ack_valid", err_valid, 1);
        tick;
        ar_valid = 0;
        err_ready = 0;
        #1;
        chk("err_done", {err_valid, err_resp}, 0);
`else
        #1;
        chk("drop_ready", ar_ready, 2'b01);
        chk("drop_wr", fifo_wr_en, 0);
        chk("drop_err", {err_valid, err_id, err_resp}, 0);
        tick;
        ar_valid = 0;
        #1;
        chk("drop_after", ar_ready, 0);
`endif
        chk("illegal_outst", dut.outst_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
